mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DW, default `WORDSIZE, data width.
REQ-002 SHALL have parameter AW, default `ADDRSIZE, address width.
REQ-003 SHALL have port clk  in  1  system clock, all state rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cpu_req_i in 1, cpu_we_i in 1, cpu_addr_i in AW, cpu_data_i in DW: CPU request, write enable, address, write data.
REQ-006 SHALL have ports cpu_ack_o out 1, cpu_data_o out DW, cpu_stall_o out 1: CPU completion pulse, read data, stall.
REQ-007 SHALL have ports dbg_req_i in 1, dbg_we_i in 1, dbg_addr_i in AW, dbg_data_i in DW: debug/keypad loader request.
REQ-008 SHALL have ports dbg_ack_o out 1, dbg_data_o out DW: debug completion pulse, read data.
REQ-009 SHALL have ports ram_addr_o out AW, ram_we_o out 1, ram_data_o out DW, ram_data_i in DW: single synchronous-read RAM port, 1-cycle read latency.
REQ-010 SHALL have port grant_dbg_o out 1: high while debug owns RAM, for LED display.

Function
REQ-011 SHALL use FSM states IDLE, ACCESS, RESP; owner register records the granted requester.
REQ-012 IDLE: any req high -> latch owner, go to ACCESS next edge; no req -> stay IDLE.
REQ-013 ACCESS: drive ram_addr_o/ram_data_o from owner's inputs; ram_we_o = owner's we; go to RESP unconditionally.
REQ-014 RESP: pulse owner's ack for exactly one cycle; owner's data_o = ram_data_i registered on that edge and held until the next ack to that port; return to IDLE.
REQ-015 Latency SHALL be fixed: request sampled in IDLE at edge N, ack high during cycle N+2 to N+3; minimum one IDLE cycle between grants.
REQ-016 Requester SHALL hold req/we/addr/data stable until ack; a req dropped early SHALL NOT abort the transaction, ack still pulses.
REQ-017 ram_we_o SHALL be high only in ACCESS; in IDLE/RESP ram_addr_o SHALL hold its last value, ram_we_o low.
REQ-018 cpu_stall_o SHALL equal cpu_req_i AND NOT cpu_ack_o, combinationally.
REQ-019 Simultaneous requests in IDLE: resolved per Configuration; loser waits, served after the winner's RESP.
REQ-020 Only one ack SHALL be high in any cycle; acks never high in IDLE or ACCESS.
REQ-021 grant_dbg_o SHALL be high in ACCESS and RESP when owner is debug.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, owner CPU, acks 0, ram_we_o 0, ram_addr_o 0, ram_data_o 0, cpu_data_o 0, dbg_data_o 0, grant_dbg_o 0, last-winner 0.
REQ-023 Reset mid-transaction SHALL discard it with no ack; first grant after release follows REQ-012.

Configuration
REQ-024 Macro MEM_ARB_ROUND_ROBIN_EN defined: on conflict, grant the port that did not win last; last-winner updates at every grant.
REQ-025 Macro undefined: fixed priority, debug always beats CPU on conflict (loader may halt CPU); last-winner logic absent.

Structure
REQ-026 State encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and owner codes SHALL live in the shared defines header beside WORDSIZE/ADDRSIZE.
REQ-027 Conflict resolution SHALL be a sub-module mem_arb_pick (inputs two reqs, last-winner; output winner), combinational, macro-dependent.

Verification
REQ-028 CPU read alone, addr 0x05 holding 0x3C: cpu_ack_o one cycle at N+2, cpu_data_o=0x3C, cpu_stall_o high cycles N..N+1.
REQ-029 Debug write 0xA5 to 0x10 then CPU read 0x10: ram_we_o high one cycle, CPU reads 0xA5.
REQ-030 Both req every cycle, 6 transactions: round-robin build -> grants alternate D,C,D,C,D,C (first conflict from reset goes to debug since last-winner=CPU); fixed build -> debug all six, CPU stalled throughout.
REQ-031 rst_n low during ACCESS of a write: ram_we_o drops immediately, no ack, state IDLE, outputs at reset values.
REQ-032 CPU drops req in ACCESS: cpu_ack_o still pulses once in RESP, no second transaction started.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the CPU/debug memory arbiter: default widths, FSM state and owner codes.
`ifndef WORDSIZE
`define WORDSIZE 8
`endif
`ifndef ADDRSIZE
`define ADDRSIZE 8
`endif

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Conflict resolver between CPU and debug requests.
// MEM_ARB_ROUND_ROBIN_EN: alternate on conflict using last winner; otherwise debug always wins.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   dbg_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  owner_e last_i,
`endif
  output owner_e winner_o
);

  always_comb begin
    winner_o = OWN_CPU;
    if (cpu_req_i && dbg_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner_o = (last_i == OWN_CPU) ? OWN_DBG : OWN_CPU;
`else
      winner_o = OWN_DBG;
`endif
    end else if (dbg_req_i) begin
      winner_o = OWN_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of one synchronous-read RAM port.
// Build option MEM_ARB_ROUND_ROBIN_EN: round-robin on conflict instead of debug-first priority.
`ifndef WORDSIZE
`define WORDSIZE 8
`endif
`ifndef ADDRSIZE
`define ADDRSIZE 8
`endif

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW = `WORDSIZE,
  parameter int AW = `ADDRSIZE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_data_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_data_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_data_i,
  output logic          dbg_ack_o,
  output logic [DW-1:0] dbg_data_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i,
  output logic          grant_dbg_o
);

  // state  | meaning
  // IDLE   | no grant; requests sampled, winner latched as owner
  // ACCESS | RAM driven with owner's address/data/we
  // RESP   | owner's ack high; RAM read data captured at the end
  state_e        state_q, state_d;
  owner_e        owner_q, owner_d, winner;
  logic          any_req;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_data_q, ram_data_d;
  logic          ram_we_q, ram_we_d;
  logic          cpu_ack_q, cpu_ack_d, dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] cpu_data_q, cpu_data_d, dbg_data_q, dbg_data_d;

  assign any_req = cpu_req_i | dbg_req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_req) last_d = winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_CPU;
    else        last_q <= last_d;
  end
`endif

  mem_arb_pick u_pick (
    .cpu_req_i (cpu_req_i),
    .dbg_req_i (dbg_req_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_i    (last_q),
`endif
    .winner_o  (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      dbg_ack_q  <= 1'b0;
      cpu_data_q <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      cpu_ack_q  <= cpu_ack_d;
      dbg_ack_q  <= dbg_ack_d;
      cpu_data_q <= cpu_data_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          owner_d = winner;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM controls are registered on the grant edge so they are valid for the whole ACCESS cycle.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    cpu_ack_d  = 1'b0;
    dbg_ack_d  = 1'b0;
    cpu_data_d = cpu_data_q;
    dbg_data_d = dbg_data_q;
    if (state_q == IDLE && any_req) begin
      if (winner == OWN_DBG) begin
        ram_addr_d = dbg_addr_i;
        ram_data_d = dbg_data_i;
        ram_we_d   = dbg_we_i;
      end else begin
        ram_addr_d = cpu_addr_i;
        ram_data_d = cpu_data_i;
        ram_we_d   = cpu_we_i;
      end
    end
    if (state_q == ACCESS) begin
      cpu_ack_d = (owner_q == OWN_CPU);
      dbg_ack_d = (owner_q == OWN_DBG);
    end
    if (state_q == RESP) begin
      if (owner_q == OWN_DBG) dbg_data_d = ram_data_i;
      else                    cpu_data_d = ram_data_i;
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign ram_data_o  = ram_data_q;
  assign ram_we_o    = ram_we_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign dbg_ack_o   = dbg_ack_q;
  assign cpu_data_o  = cpu_data_q;
  assign dbg_data_o  = dbg_data_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;
  assign grant_dbg_o = (state_q != IDLE) && (owner_q == OWN_DBG);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grant order, ack cycle
// and read data; a negedge monitor compares every ack against the predicted queue.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_v [2];
  logic       we_v [2];
  logic [7:0] addr_v [2];
  logic [7:0] data_v [2];
  logic       cpu_ack_o, cpu_stall_o, dbg_ack_o, ram_we_o, grant_dbg_o;
  logic [7:0] cpu_data_o, dbg_data_o, ram_addr_o, ram_data_o, ram_rdata;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] rdata;
    int         ack_cyc;
  } exp_t;
  exp_t expq [$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   free_cyc = 0;
  bit   model_en = 0;
  bit   mw;
  bit   last_dbg = 0;
  exp_t me, ce;
  bit   dchk = 0;
  bit   dport;
  logic [7:0] dexp;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(8), .AW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req_i   (req_v[0]),
    .cpu_we_i    (we_v[0]),
    .cpu_addr_i  (addr_v[0]),
    .cpu_data_i  (data_v[0]),
    .cpu_ack_o   (cpu_ack_o),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .dbg_req_i   (req_v[1]),
    .dbg_we_i    (we_v[1]),
    .dbg_addr_i  (addr_v[1]),
    .dbg_data_i  (data_v[1]),
    .dbg_ack_o   (dbg_ack_o),
    .dbg_data_o  (dbg_data_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_data_o  (ram_data_o),
    .ram_data_i  (ram_rdata),
    .grant_dbg_o (grant_dbg_o)
  );

  // Behavioural synchronous RAM, read-first, one cycle latency.
  always @(posedge clk) begin
    if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
    ram_rdata <= mem[ram_addr_o];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Transaction-level model: whenever the arbiter is free and someone requests, pick by rule,
  // apply the access to the reference memory and predict the ack two edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= 0;
      free_cyc <= 0;
      last_dbg = 0;
    end else begin
      cyc <= cyc + 1;
      if (model_en && cyc >= free_cyc && (req_v[0] || req_v[1])) begin
        if (req_v[0] && req_v[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          mw = !last_dbg;
`else
          mw = 1'b1;
`endif
        end else begin
          mw = req_v[1];
        end
        last_dbg   = mw;
        me.port    = mw;
        me.we      = we_v[mw];
        me.rdata   = ref_mem[addr_v[mw]];
        me.ack_cyc = cyc + 2;
        if (we_v[mw]) ref_mem[addr_v[mw]] = data_v[mw];
        expq.push_back(me);
        free_cyc <= cyc + 3;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cpu_stall", {31'd0, cpu_stall_o}, {31'd0, req_v[0] && !cpu_ack_o});
      if (dchk) begin
        chk(dport ? "dbg_rdata" : "cpu_rdata", {24'd0, dport ? dbg_data_o : cpu_data_o}, {24'd0, dexp});
        dchk = 0;
      end
      if (cpu_ack_o || dbg_ack_o) begin
        chk("single_ack", {31'd0, cpu_ack_o && dbg_ack_o}, 32'd0);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack got cpu=%0b dbg=%0b want no ack", cpu_ack_o, dbg_ack_o);
        end else begin
          ce = expq.pop_front();
          chk("ack_port", {31'd0, dbg_ack_o}, {31'd0, ce.port});
          chk("ack_cycle", cyc, ce.ack_cyc);
          chk("grant_dbg", {31'd0, grant_dbg_o}, {31'd0, ce.port});
          if (!ce.we) begin
            dchk  = 1;
            dport = ce.port;
            dexp  = ce.rdata;
          end
        end
      end
    end
  end

  task automatic txn(input int p, input logic we, input logic [7:0] a, input logic [7:0] d, input bit drop);
    int n = 0;
    we_v[p]   = we;
    addr_v[p] = a;
    data_v[p] = d;
    req_v[p]  = 1'b1;
    if (drop) begin
      @(posedge clk);
      #1;
      req_v[p] = 1'b0;
    end
    while (n < 300) begin
      @(negedge clk);
      if ((p == 0) ? cpu_ack_o : dbg_ack_o) break;
      n++;
    end
    chk("ack_timeout", {31'd0, n >= 300}, 32'd0);
    @(posedge clk);
    #1;
    req_v[p] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 0; we_v[i] = 0; addr_v[i] = 0; data_v[i] = 0;
    end
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[5]     = 8'h3C;
    ref_mem[5] = 8'h3C;

    #12;
    chk("rst_cpu_ack", {31'd0, cpu_ack_o}, 32'd0);
    chk("rst_dbg_ack", {31'd0, dbg_ack_o}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we_o}, 32'd0);
    chk("rst_ram_addr", {24'd0, ram_addr_o}, 32'd0);
    chk("rst_grant_dbg", {31'd0, grant_dbg_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    model_en = 1;
    idle(2);

    txn(0, 1'b0, 8'h05, 8'h00, 0);
    txn(1, 1'b1, 8'h10, 8'hA5, 0);
    txn(0, 1'b0, 8'h10, 8'h00, 0);
    idle(4);

    fork
      begin
        txn(0, 1'b0, 8'h10, 8'h00, 0);
        txn(0, 1'b1, 8'h11, 8'h6B, 0);
        txn(0, 1'b0, 8'h12, 8'h00, 0);
      end
      begin
        txn(1, 1'b1, 8'h12, 8'hC3, 0);
        txn(1, 1'b0, 8'h11, 8'h00, 0);
        txn(1, 1'b1, 8'h10, 8'h0F, 0);
      end
    join
    idle(4);

    fork
      begin
        for (int k = 0; k < 20; k++) begin
          idle($urandom_range(0, 3));
          txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), 0);
        end
      end
      begin
        for (int k = 0; k < 20; k++) begin
          idle($urandom_range(0, 3));
          txn(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), 0);
        end
      end
    join
    idle(6);
    chk("drain_random", expq.size(), 32'd0);

    txn(0, 1'b0, 8'h07, 8'h00, 1);
    idle(8);
    chk("drop_early_single", expq.size(), 32'd0);

    model_en  = 0;
    we_v[0]   = 1'b1;
    addr_v[0] = 8'h22;
    data_v[0] = 8'h77;
    req_v[0]  = 1'b1;
    @(posedge clk);
    #1;
    chk("access_we", {31'd0, ram_we_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_we", {31'd0, ram_we_o}, 32'd0);
    chk("mid_rst_ram_addr", {24'd0, ram_addr_o}, 32'd0);
    chk("mid_rst_ram_data", {24'd0, ram_data_o}, 32'd0);
    chk("mid_rst_cpu_data", {24'd0, cpu_data_o}, 32'd0);
    chk("mid_rst_dbg_data", {24'd0, dbg_data_o}, 32'd0);
    chk("mid_rst_acks", {30'd0, cpu_ack_o, dbg_ack_o}, 32'd0);
    chk("mid_rst_grant", {31'd0, grant_dbg_o}, 32'd0);
    req_v[0] = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    chk("rst_no_write", {24'd0, mem[8'h22]}, {24'd0, ref_mem[8'h22]});
    model_en = 1;
    txn(0, 1'b0, 8'h22, 8'h00, 0);
    idle(4);
    chk("final_drain", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
